// File: rtl/pc_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM states, bubble
// instruction and a saturating counter helper.
package pc_fetch_unit_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

    localparam logic [15:0] REDIR_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == REDIR_CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus: branch-unit redirect, hazard stall, instruction memory
// read data in; fetch address, IF/ID contents and status out.
interface pc_fetch_unit_if #(parameter int PC_W = 9);

    logic            PcSel;
    logic [31:0]     BrPC;
    logic            Halt;
    logic            Stall;
    logic [31:0]     Instr;
    logic [PC_W-1:0] PC;
    logic [PC_W-1:0] IfId_PC;
    logic [31:0]     IfId_Instr;
    logic            IfId_Valid;
    logic            Flush;
    logic            Halted;
    logic            Misalign;
    logic [15:0]     RedirCnt;

    // Pipeline / environment side
    modport master (
        output PcSel, BrPC, Halt, Stall, Instr,
        input  PC, IfId_PC, IfId_Instr, IfId_Valid, Flush, Halted, Misalign, RedirCnt
    );

    // Fetch unit side
    modport slave (
        input  PcSel, BrPC, Halt, Stall, Instr,
        output PC, IfId_PC, IfId_Instr, IfId_Valid, Flush, Halted, Misalign, RedirCnt
    );

endinterface

// File: rtl/pc_fetch_unit_ifid.sv
// IF/ID pipeline register with hold, flush (bubble) and load.
module ifid_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter int          PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            hold,
    input  logic [PC_W-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [PC_W-1:0] ifid_pc,
    output logic [31:0]     ifid_instr,
    output logic            ifid_valid
);

    // Reset and flush both insert a bubble; flush beats hold.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ifid_pc    <= '0;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else if (!hold) begin
            ifid_pc    <= load_pc;
            ifid_instr <= load_instr;
            ifid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch unit: PC register, RUN/HALTED FSM, redirect counter and misalign
// flag; the IF/ID register lives in ifid_reg.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int          PC_W      = 9,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    pc_fetch_unit_if.slave       bus
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic [15:0]     redir_cnt_q;
    logic            misalign_q;
    logic            running;
    logic            redirect;
    logic            unused_br_hi;

    assign running  = (state_q == RUN);
    assign redirect = bus.PcSel && running;

    // Only the word-aligned in-range part of the target is kept.
    assign unused_br_hi = ^bus.BrPC[31:PC_W];

    // Status outputs are masked while reset is asserted, before the
    // registers have had a chance to clear.
    assign bus.Flush    = redirect && !reset;
    assign bus.Halted   = (state_q == HALTED) && !reset;
    assign bus.PC       = pc_q;
    assign bus.RedirCnt = redir_cnt_q;
    assign bus.Misalign = misalign_q;

    // FSM, PC, redirect counter and sticky misalign flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= '0;
            redir_cnt_q <= '0;
            misalign_q  <= 1'b0;
        end else if (running) begin
            if (bus.PcSel) begin
                pc_q        <= {bus.BrPC[PC_W-1:2], 2'b00};
                redir_cnt_q <= sat_inc16(redir_cnt_q);
                if (bus.BrPC[1:0] != 2'b00) begin
                    misalign_q <= 1'b1;
                end
                if (bus.Halt) begin
                    state_q <= HALTED;
                end
            end else if (!bus.Stall) begin
                pc_q <= pc_q + PC_W'(4);
            end
        end
    end

    ifid_reg #(
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .hold       (!running || bus.Stall),
        .load_pc    (pc_q),
        .load_instr (bus.Instr),
        .ifid_pc    (bus.IfId_PC),
        .ifid_instr (bus.IfId_Instr),
        .ifid_valid (bus.IfId_Valid)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit against a behavioural fetch model.
module tb_pc_fetch_unit;

    localparam int          PC_W  = 9;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          PC_MOD = 1 << PC_W;

    logic clk = 1'b0;
    logic reset;

    pc_fetch_unit_if #(.PC_W(PC_W)) bus ();

    pc_fetch_unit #(.PC_W(PC_W), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int          m_pc;
    int          m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_valid;
    logic        m_halted;
    logic        m_mis;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ifid_pc = 0; m_ifid_instr = NOP; m_valid = 0;
        m_halted = 0; m_mis = 0; m_cnt = 0;
    endtask

    // One clock: drive at negedge, check combinational outputs, then
    // advance the model at the edge and check the registered state.
    task automatic step(input logic r, input logic ps, input logic [31:0] br,
                        input logic h, input logic st);
        logic [31:0] ins;
        ins = $urandom;
        @(negedge clk);
        reset = r; bus.PcSel = ps; bus.BrPC = br; bus.Halt = h;
        bus.Stall = st; bus.Instr = ins;
        #1;
        check("flush", 32'(bus.Flush), 32'(ps && !m_halted && !r));
        if (r) check("halted_in_reset", 32'(bus.Halted), 32'd0);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (!m_halted) begin
            if (ps) begin
                if (m_cnt < 65535) m_cnt++;
                if (br[1:0] != 2'b00) m_mis = 1;
                m_pc = int'(br % PC_MOD) / 4 * 4;
                m_ifid_pc = 0; m_ifid_instr = NOP; m_valid = 0;
                if (h) m_halted = 1;
            end else if (!st) begin
                m_ifid_pc = m_pc; m_ifid_instr = ins; m_valid = 1;
                m_pc = (m_pc + 4) % PC_MOD;
            end
        end
        #1;
        check("pc",         32'(bus.PC),         32'(m_pc));
        check("ifid_pc",    32'(bus.IfId_PC),    32'(m_ifid_pc));
        check("ifid_instr", bus.IfId_Instr,      m_ifid_instr);
        check("ifid_valid", 32'(bus.IfId_Valid), 32'(m_valid));
        check("misalign",   32'(bus.Misalign),   32'(m_mis));
        check("redir_cnt",  32'(bus.RedirCnt),   32'(m_cnt));
        if (!r) check("halted", 32'(bus.Halted), 32'(m_halted));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic [31:0] br, input logic st);
        step(1'b0, 1'b1, br, 1'b0, st);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; bus.PcSel = 1'b0; bus.BrPC = '0; bus.Halt = 1'b0;
        bus.Stall = 1'b0; bus.Instr = '0;

        // Reset overrides a simultaneous halt redirect
        step(1'b1, 1'b1, 32'h1FC, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h1FC, 1'b1, 1'b0);
        check("reset_pc", 32'(bus.PC), 32'h0);
        check("reset_instr", bus.IfId_Instr, NOP);

        // Sequential fetch from 0
        repeat (4) idle();
        check("seq_pc_0x10", 32'(bus.PC), 32'h10);
        check("seq_ifid_pc", 32'(bus.IfId_PC), 32'hC);

        // Redirect to 0x40 from PC 0x10
        redir(32'h40, 1'b0);
        check("redir_pc", 32'(bus.PC), 32'h40);
        idle();
        check("redir_ifid_pc", 32'(bus.IfId_PC), 32'h40);
        check("redir_valid", 32'(bus.IfId_Valid), 32'd1);
        check("redir_cnt1", 32'(bus.RedirCnt), 32'd1);

        // Redirect beats stall; then stall alone holds
        idle();
        redir(32'h80, 1'b1);
        check("stall_redir_pc", 32'(bus.PC), 32'h80);
        idle();
        repeat (3) step(1'b0, 1'b0, $urandom, 1'b0, 1'b1);

        // Random run without halt
        repeat (40) step(1'b0, 1'($urandom_range(0, 3) == 0), $urandom,
                         1'b0, 1'($urandom_range(0, 2) == 0));

        // Misalign with dropped upper bits, stays sticky
        redir(32'h203, 1'b0);
        check("mis_pc", 32'(bus.PC), 32'h0);
        check("mis_flag", 32'(bus.Misalign), 32'd1);
        redir(32'h100, 1'b0);
        check("mis_sticky", 32'(bus.Misalign), 32'd1);

        // PC wrap
        redir(32'h1FC, 1'b0);
        idle();
        check("pc_wrap", 32'(bus.PC), 32'h0);

        // Back-to-back redirects up to 0xFFFE, then saturate
        while (m_cnt < 32'hFFFE) redir($urandom & 32'h1FC, 1'b0);
        check("cnt_fffe", 32'(bus.RedirCnt), 32'hFFFE);
        redir(32'h24, 1'b0);
        check("cnt_ffff", 32'(bus.RedirCnt), 32'hFFFF);
        redir(32'h28, 1'b0);
        check("cnt_hold", 32'(bus.RedirCnt), 32'hFFFF);
        check("last_target", 32'(bus.PC), 32'h28);

        // Halt redirect, then everything ignored
        idle();
        step(1'b0, 1'b1, 32'h1FC, 1'b1, 1'b0);
        check("halt_pc", 32'(bus.PC), 32'h1FC);
        check("halt_flag", 32'(bus.Halted), 32'd1);
        repeat (5) step(1'b0, 1'($urandom_range(0, 1)), $urandom,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("halt_hold_pc", 32'(bus.PC), 32'h1FC);

        // Reset leaves HALTED
        step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0);
        check("post_halt_pc", 32'(bus.PC), 32'h0);
        idle();
        check("post_halt_flag", 32'(bus.Halted), 32'd0);
        check("post_halt_pc2", 32'(bus.PC), 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
